// File: rtl/dla_stim_pkg.sv
// Shared types and LFSR helpers for the dla_stim_gen stimulus source.
// Optional signature logic is enabled with the DLA_STIM_SIGNATURE_EN macro.
package dla_stim_pkg;

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_e;

   // Galois feedback constants for the supported data widths.
   function automatic logic [31:0] lfsr_taps(input int unsigned width);
      case (width)
         8:       return 32'h0000_00B8;
         16:      return 32'h0000_B400;
         default: return 32'h8020_0003;
      endcase
   endfunction

   function automatic logic [31:0] lfsr_next(input logic [31:0] state, input int unsigned width);
      logic [31:0] nxt;
      nxt = state >> 1;
      if (state[0]) begin
         nxt = nxt ^ lfsr_taps(width);
      end
      return nxt;
   endfunction

   // Per-channel seed: base + channel, truncated to width, never zero.
   function automatic logic [31:0] lfsr_seed(input int unsigned base, input int unsigned ch,
                                             input int unsigned width);
      logic [31:0] s;
      s = 32'(base + ch);
      if (width < 32) begin
         s = s & ((32'd1 << width) - 32'd1);
      end
      if (s == 32'd0) begin
         s = 32'd1;
      end
      return s;
   endfunction

endpackage

// File: rtl/dla_stim_lane.sv
// One stimulus channel: LFSR data, saturating beat counter, valid register,
// and (with DLA_STIM_SIGNATURE_EN) a rotate-XOR signature register.
module dla_stim_lane
   import dla_stim_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned BURST_LEN = 256,
   parameter int unsigned SEED      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data,
   output logic             fin_c
`ifdef DLA_STIM_SIGNATURE_EN
   ,
   output logic [WIDTH-1:0] sig_nxt_c
`endif
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN);
   localparam logic [WIDTH-1:0] SEED_W = WIDTH'(SEED);

   logic [CNT_W-1:0] cnt;
   logic             xfer_c;

   assign xfer_c = valid && ready && en;

   // Finished once saturated, or on the cycle the final beat transfers.
   assign fin_c = (cnt == LAST) || (xfer_c && (cnt == (LAST - CNT_W'(1))));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data  <= SEED_W;
         cnt   <= '0;
         valid <= 1'b0;
      end else if (load) begin
         data  <= SEED_W;
         cnt   <= '0;
         valid <= 1'b1;
      end else if (!en) begin
         valid <= 1'b0;
      end else if (xfer_c) begin
         data  <= WIDTH'(lfsr_next(32'(data), WIDTH));
         cnt   <= cnt + CNT_W'(1);
         valid <= (cnt + CNT_W'(1)) != LAST;
      end
   end

`ifdef DLA_STIM_SIGNATURE_EN
   logic [WIDTH-1:0] sig;

   assign sig_nxt_c = load   ? '0 :
                      xfer_c ? ({sig[WIDTH-2:0], sig[WIDTH-1]} ^ data) :
                               sig;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig <= '0;
      end else begin
         sig <= sig_nxt_c;
      end
   end
`endif

endmodule

// File: rtl/dla_stim_gen.sv
// Multi-channel LFSR stimulus source with start/abort control and completion status.
// Define DLA_STIM_SIGNATURE_EN to add the o_signature output.
module dla_stim_gen
   import dla_stim_pkg::*;
#(
   parameter int unsigned NUM_CH    = 24,
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned BURST_LEN = 256,
   parameter int unsigned SEED_BASE = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_start,
   input  logic                    i_abort,
   input  logic [NUM_CH-1:0]       i_ready,
   output logic [NUM_CH-1:0]       o_valid,
   output logic [NUM_CH*WIDTH-1:0] o_data,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_aborted
`ifdef DLA_STIM_SIGNATURE_EN
   ,
   output logic [WIDTH-1:0]        o_signature
`endif
);

   state_e              state;
   logic                load_c;
   logic                en_c;
   logic                all_fin_c;
   logic [NUM_CH-1:0]   fin_c;
`ifdef DLA_STIM_SIGNATURE_EN
   logic [WIDTH-1:0]    sig_nxt [NUM_CH];
   logic [WIDTH-1:0]    sig_xor_c;
`endif

   // Abort takes priority: lanes are disabled in the same cycle it is seen.
   assign load_c    = i_start && (state != RUN);
   assign en_c      = (state == RUN) && !i_abort;
   assign all_fin_c = &fin_c;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
      dla_stim_lane #(
         .WIDTH     (WIDTH),
         .BURST_LEN (BURST_LEN),
         .SEED      (int'(lfsr_seed(SEED_BASE, c, WIDTH)))
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .load      (load_c),
         .en        (en_c),
         .ready     (i_ready[c]),
         .valid     (o_valid[c]),
         .data      (o_data[c*WIDTH +: WIDTH]),
         .fin_c     (fin_c[c])
`ifdef DLA_STIM_SIGNATURE_EN
         ,
         .sig_nxt_c (sig_nxt[c])
`endif
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_aborted <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (i_start) begin
                  state     <= RUN;
                  o_busy    <= 1'b1;
                  o_done    <= 1'b0;
                  o_aborted <= 1'b0;
               end
            end
            RUN: begin
               if (i_abort) begin
                  state     <= IDLE;
                  o_busy    <= 1'b0;
                  o_done    <= 1'b0;
                  o_aborted <= 1'b1;
               end else if (all_fin_c) begin
                  state  <= DONE;
                  o_busy <= 1'b0;
                  o_done <= 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               o_busy <= 1'b0;
               o_done <= 1'b0;
            end
         endcase
      end
   end

`ifdef DLA_STIM_SIGNATURE_EN
   // Fold all lane signatures; registered alongside the lane registers.
   always_comb begin
      sig_xor_c = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         sig_xor_c = sig_xor_c ^ sig_nxt[c];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_signature <= '0;
      end else begin
         o_signature <= sig_xor_c;
      end
   end
`endif

endmodule

// File: tb/tb_dla_stim_gen.sv
// Self-checking bench for dla_stim_gen: scoreboard of expected beats plus a scenario table.
// With DLA_STIM_SIGNATURE_EN a second small instance checks the signature output.
module tb_dla_stim_gen;

   localparam int NCH = 2;
   localparam int W   = 16;
   localparam int BL  = 4;

   logic                clk = 1'b0;
   logic                rst;
   logic                i_start;
   logic                i_abort;
   logic [NCH-1:0]      i_ready;
   logic [NCH-1:0]      o_valid;
   logic [NCH*W-1:0]    o_data;
   logic                o_busy;
   logic                o_done;
   logic                o_aborted;
`ifdef DLA_STIM_SIGNATURE_EN
   logic [W-1:0]        o_signature;
   logic [0:0]          s_ready;
   logic [0:0]          s_valid;
   logic [7:0]          s_data;
   logic                s_busy;
   logic                s_done;
   logic                s_aborted;
   logic [7:0]          s_signature;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] q0[$];
   logic [W-1:0] q1[$];

   typedef struct {
      int s0;
      int s1;
      int start_at;
      int exp_busy;
   } scn_t;

   scn_t tbl[4];

   always #5 clk = ~clk;

   dla_stim_gen #(
      .NUM_CH    (NCH),
      .WIDTH     (W),
      .BURST_LEN (BL),
      .SEED_BASE (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_abort     (i_abort),
      .i_ready     (i_ready),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .o_busy      (o_busy),
      .o_done      (o_done),
      .o_aborted   (o_aborted)
`ifdef DLA_STIM_SIGNATURE_EN
      ,
      .o_signature (o_signature)
`endif
   );

`ifdef DLA_STIM_SIGNATURE_EN
   dla_stim_gen #(
      .NUM_CH    (1),
      .WIDTH     (8),
      .BURST_LEN (2),
      .SEED_BASE (0)
   ) u_sig (
      .clk         (clk),
      .rst         (rst),
      .i_start     (i_start),
      .i_abort     (i_abort),
      .i_ready     (s_ready),
      .o_valid     (s_valid),
      .o_data      (s_data),
      .o_busy      (s_busy),
      .o_done      (s_done),
      .o_aborted   (s_aborted),
      .o_signature (s_signature)
   );
`endif

   function automatic logic [W-1:0] model_next(input logic [W-1:0] s);
      return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
      end
   endtask

   // Expected beats for a fresh run: seeds 1 and 2, BL steps each.
   task automatic push_run();
      logic [W-1:0] s0;
      logic [W-1:0] s1;
      q0.delete();
      q1.delete();
      s0 = 16'h0001;
      s1 = 16'h0002;
      for (int i = 0; i < BL; i++) begin
         q0.push_back(s0);
         q1.push_back(s1);
         s0 = model_next(s0);
         s1 = model_next(s1);
      end
   endtask

   task automatic sb_chan(input int c, input logic rdy);
      logic [W-1:0] d;
      int           sz;
      d  = o_data[c*W +: W];
      sz = (c == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL extra_beat ch%0d: valid with data 0x%h, expected no further beats", c, d);
      end else if (c == 0) begin
         check("data_ch0", 32'(d), 32'(q0[0]));
         if (rdy) void'(q0.pop_front());
      end else begin
         check("data_ch1", 32'(d), 32'(q1[0]));
         if (rdy) void'(q1.pop_front());
      end
   endtask

   // Drive inputs for the coming edge at the falling edge, then score the handshake.
   task automatic step(input logic [NCH-1:0] rdy, input logic st, input logic ab);
      @(negedge clk);
      i_ready = rdy;
      i_start = st;
      i_abort = ab;
      for (int c = 0; c < NCH; c++) begin
         if (o_valid[c]) sb_chan(c, rdy[c]);
      end
   endtask

   task automatic run_scn(input int s0, input int s1, input int st_at, input int exp_busy);
      int busy;
      logic seen;
      busy = 0;
      seen = 1'b0;
      step(2'b00, 1'b1, 1'b0);
      push_run();
      for (int cyc = 1; cyc <= 200 && !seen; cyc++) begin
         step({cyc > s1, cyc > s0}, cyc == st_at, 1'b0);
         if (cyc == 1) check("valid_first_cycle", 32'(o_valid), 32'h3);
         if (o_busy) busy++;
         if (o_done) seen = 1'b1;
      end
      check("done_seen", 32'(seen), 32'h1);
      check("busy_cycles", 32'(busy), 32'(exp_busy));
      check("valid_after_done", 32'(o_valid), 32'h0);
      check("ch0_beats_left", 32'(q0.size()), 32'h0);
      check("ch1_beats_left", 32'(q1.size()), 32'h0);
      check("aborted_clear", 32'(o_aborted), 32'h0);
   endtask

   initial begin
      rst     = 1'b1;
      i_start = 1'b0;
      i_abort = 1'b0;
      i_ready = '0;
`ifdef DLA_STIM_SIGNATURE_EN
      s_ready = 1'b1;
`endif
      tbl[0] = '{s0: 0, s1: 0,  start_at: 0, exp_busy: 4};
      tbl[1] = '{s0: 0, s1: 10, start_at: 0, exp_busy: 14};
      tbl[2] = '{s0: 3, s1: 1,  start_at: 2, exp_busy: 7};
      tbl[3] = '{s0: 2, s1: 2,  start_at: 5, exp_busy: 6};

      repeat (2) @(negedge clk);
      check("rst_valid", 32'(o_valid), 32'h0);
      check("rst_busy", 32'(o_busy), 32'h0);
      check("rst_done", 32'(o_done), 32'h0);
      check("rst_aborted", 32'(o_aborted), 32'h0);
      rst = 1'b0;

      // First run: seeds and first LFSR step, then completion timing.
      step(2'b00, 1'b1, 1'b0);
      push_run();
      step(2'b11, 1'b0, 1'b0);
      check("first_beat_data", o_data, 32'h0002_0001);
      check("first_beat_busy", 32'(o_busy), 32'h1);
      step(2'b11, 1'b0, 1'b0);
      check("second_beat_data", o_data, 32'h0001_B400);
      step(2'b11, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0);
      check("done_after_last", 32'(o_done), 32'h1);
      check("busy_after_last", 32'(o_busy), 32'h0);
      check("valid_after_last", 32'(o_valid), 32'h0);
`ifdef DLA_STIM_SIGNATURE_EN
      check("sig_final", 32'(s_signature), 32'h0000_00BA);
      check("sig_done", 32'(s_done), 32'h1);
`endif

      for (int i = 0; i < 4; i++) begin
         run_scn(tbl[i].s0, tbl[i].s1, tbl[i].start_at, tbl[i].exp_busy);
      end

      // Abort on the second beat, with a simultaneous start that must lose.
      step(2'b00, 1'b1, 1'b0);
      push_run();
      step(2'b11, 1'b0, 1'b0);
      step(2'b11, 1'b1, 1'b1);
      step(2'b11, 1'b0, 1'b0);
      check("abort_valid", 32'(o_valid), 32'h0);
      check("abort_busy", 32'(o_busy), 32'h0);
      check("abort_done", 32'(o_done), 32'h0);
      check("abort_flag", 32'(o_aborted), 32'h1);
      step(2'b11, 1'b0, 1'b0);
      check("abort_flag_sticky", 32'(o_aborted), 32'h1);
      check("abort_stays_idle", 32'(o_busy), 32'h0);
      run_scn(0, 0, 0, 4);

      // Asynchronous reset between clock edges in the middle of a run.
      step(2'b00, 1'b1, 1'b0);
      push_run();
      step(2'b11, 1'b0, 1'b0);
      step(2'b11, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_valid", 32'(o_valid), 32'h0);
      check("async_rst_busy", 32'(o_busy), 32'h0);
      check("async_rst_data", o_data, 32'h0002_0001);
      @(negedge clk);
      rst = 1'b0;
      q0.delete();
      q1.delete();
      for (int i = 0; i < 5; i++) begin
         step(2'b11, 1'b0, 1'b0);
         check("post_rst_idle", 32'(o_busy), 32'h0);
      end
      run_scn(1, 0, 0, 5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dla_stim_gen.md
Name: dla_stim_gen

Overview:
- Parametrised multi-channel pseudo-random stimulus source for DLA-class accelerator benches and on-chip self-test.
- Each channel has one Galois LFSR data stream with a valid/ready handshake and a programmable burst length.
- Replaces fixed per-lane free-running generators with start/abort control, back-pressure and completion status.
- Sits between the top-level harness and the accelerator DDR-side write ports.

Parameters:
- NUM_CH, 24, number of independent stimulus channels (1..64).
- WIDTH, 16, data width per channel; legal values are 8, 16 and 32.
- BURST_LEN, 256, beats per channel per run (1..65535).
- SEED_BASE, 1, channel c seed = SEED_BASE + c, truncated to WIDTH; a zero result is replaced by 1.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse; starts a run when IDLE or DONE, ignored in RUN.
- i_abort  in  1  one-cycle pulse; ends a RUN immediately.
- i_ready  in  NUM_CH  per-channel consumer ready.
- o_valid  out  NUM_CH  per-channel data valid.
- o_data  out  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- o_busy  out  1  high while in RUN.
- o_done  out  1  high in DONE; low after an abort.
- o_aborted  out  1  sticky; set by abort, cleared by the next start.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high, ports named clk and rst.
- Reset values: FSM=IDLE; all o_valid=0; o_busy=0; o_done=0; o_aborted=0; every LFSR=its seed; beat counters=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE or DONE + i_start -> RUN. On this transition: reload all LFSRs with their seeds, clear counters, clear o_done and o_aborted.
  - RUN -> DONE in the cycle after the last channel's final beat handshake completes.
  - RUN + i_abort -> IDLE next cycle; o_valid drops to 0 and o_aborted=1.
  - i_abort and i_start in the same cycle: abort wins; i_start is ignored in RUN anyway.
- o_valid[c]: asserted the cycle after entry to RUN. Held while channel c's counter < BURST_LEN, then deasserted.
- Handshake: a beat transfers when o_valid[c] && i_ready[c].
  - On a transfer: LFSR[c] advances one step and counter[c] increments.
  - Otherwise o_data slice c holds stable (AXI-style; no valid-depends-on-ready).
- The first beat of each run equals the channel seed. Latency from start to first valid is 1 cycle.
- LFSR step (Galois, right shift): lsb = s[0]; s = s >> 1; if lsb then s ^= TAPS[WIDTH].
  - TAPS: 8 -> 0xB8; 16 -> 0xB400; 32 -> 0x80200003. All are maximal length, so the all-zero state is never reached.
- Channels are fully independent: back-pressure on one channel never stalls another.
- Counter width is 16 bits. Counters saturate at BURST_LEN and do not wrap.
- BURST_LEN=1: exactly one beat per channel, then DONE.
- Reset asserted mid-run: immediate return to reset values (asynchronous).
- Outputs are registered; no combinational path from i_ready to o_valid or o_data.

Optional Feature:
- Macro: DLA_STIM_SIGNATURE_EN.
- When defined:
  - Adds output o_signature [WIDTH] plus a per-channel XOR-fold MISR.
  - Per transfer on channel c: sig = {sig[WIDTH-2:0], sig[WIDTH-1]} ^ data_c.
  - o_signature is the XOR of all channel signatures, updated in registers. It is cleared on reset and on start, and held in DONE.
- When undefined: the port and logic are absent, and all other behaviour is identical.

Decomposition:
- Package dla_stim_pkg holds:
  - state_e enum (IDLE, RUN, DONE);
  - function lfsr_taps(width) returning the TAPS constants;
  - function lfsr_next(state, width);
  - localparam CNT_W = 16.
- Sub-module dla_stim_lane: one LFSR, beat counter, valid register and optional MISR, with inputs load/en/ready.
- The top level generates NUM_CH lanes and owns the FSM and the done reduction.

Test Plan:
- Reset then start, NUM_CH=2, WIDTH=16, SEED_BASE=1, i_ready=all-1 -> cycle 1: ch0 data 0x0001, ch1 data 0x0002; next beat ch0 = 0xB400, ch1 = 0x0001.
- BURST_LEN=4, all ready -> exactly 4 transfers per channel; o_busy falls and o_done rises the cycle after the 4th beat; o_valid=0 afterwards.
- ch1 ready low for 10 cycles, ch0 ready high -> ch0 finishes at 4 beats; ch1 data frozen at its seed; DONE only after ch1's 4th transfer.
- Abort asserted on the 2nd beat -> next cycle IDLE, o_valid=0, o_aborted=1, o_done=0; restart replays from seed 0x0001 and clears o_aborted.
- Async reset pulse in the middle of RUN, between clock edges -> outputs at reset values before the next edge; no further beats.
- With DLA_STIM_SIGNATURE_EN, NUM_CH=1, WIDTH=8, BURST_LEN=2, seed=1 -> beats 0x01, 0xB8; after beat 1 sig=0x01; final sig = 0x02 ^ 0xB8 = 0xBA.
